// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants for the multicycle control unit: state encodings, default
// opcodes and the bundle of registered datapath strobes.
package mcu_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  localparam int OPW_DEF      = 6;
  localparam int OP_RTYPE_DEF = 0;
  localparam int OP_BEQ_DEF   = 4;
  localparam int OP_LW_DEF    = 35;
  localparam int OP_SW_DEF    = 43;
  localparam int OP_ADDI_DEF  = 8;
  localparam int TMO_DEF      = 15;

  typedef struct packed {
    logic alu_src;
    logic mem_to_reg;
    logic reg_dst;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic ir_write;
    logic pc_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction/memory handshake and datapath strobe bundle between the control
// unit (slave) and the datapath/bench that drives it (master).
interface mcu_if
  import mcu_pkg::*;
#(
  parameter int OPW = OPW_DEF
);

  logic [OPW-1:0] Opcode;
  logic           Zero;
  logic           MemReady;

  logic           ALUSrc;
  logic           MemtoReg;
  logic           RegDst;
  logic           RegWrite;
  logic           MemRead;
  logic           MemWrite;
  logic           Branch;
  logic           IRWrite;
  logic           PCWrite;
  logic           IllegalOp;
  logic           BusError;
  logic [2:0]     State;

  modport master (
    output Opcode, Zero, MemReady,
    input  ALUSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite,
    input  Branch, IRWrite, PCWrite, IllegalOp, BusError, State
  );

  modport slave (
    input  Opcode, Zero, MemReady,
    output ALUSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite,
    output Branch, IRWrite, PCWrite, IllegalOp, BusError, State
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait counter: cleared on entry to a wait state, counts stalled cycles,
// flags expiry on the stalled cycle that would bring it to TMO.
module mem_wait_timer
  import mcu_pkg::*;
#(
  parameter int TMO = TMO_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TMO < 1) ? 1 : $clog2(TMO + 1);
  localparam logic [CW-1:0] LAST = CW'(TMO - 1);
  localparam logic [CW-1:0] TOP  = CW'(TMO);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != TOP)) begin
      count_d = count_q + CW'(1);
    end
  end

  // A ready cycle never enables the count, so success at the limit cannot expire.
  assign expired = enable && (count_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle instruction sequencer with registered Moore strobes, memory wait
// timeout and sticky illegal-opcode / bus-error traps.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OPW      = OPW_DEF,
  parameter int OP_RTYPE = OP_RTYPE_DEF,
  parameter int OP_BEQ   = OP_BEQ_DEF,
  parameter int OP_LW    = OP_LW_DEF,
  parameter int OP_SW    = OP_SW_DEF,
  parameter int OP_ADDI  = OP_ADDI_DEF,
  parameter int TMO      = TMO_DEF
) (
  input logic  CLK,
  input logic  Reset,
  mcu_if.slave bus
);

  // states: IDLE reset | FETCH instr wait | DECODE | EXEC | MEM data wait | WB | TRAP absorbing
  localparam logic [OPW-1:0] OPC_R    = OPW'(OP_RTYPE);
  localparam logic [OPW-1:0] OPC_BEQ  = OPW'(OP_BEQ);
  localparam logic [OPW-1:0] OPC_LW   = OPW'(OP_LW);
  localparam logic [OPW-1:0] OPC_SW   = OPW'(OP_SW);
  localparam logic [OPW-1:0] OPC_ADDI = OPW'(OP_ADDI);

  logic [2:0]     state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  ctrl_t          ctrl_q, ctrl_d;
  logic           illegal_q, illegal_d;
  logic           bus_err_q, bus_err_d;
  logic           tmr_clear, tmr_en, tmr_expired;
  logic           in_wait;

  function automatic logic op_supported(input logic [OPW-1:0] op);
    return (op == OPC_R) || (op == OPC_BEQ) || (op == OPC_LW) ||
           (op == OPC_SW) || (op == OPC_ADDI);
  endfunction

  assign in_wait   = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign tmr_en    = in_wait && !bus.MemReady;
  assign tmr_clear = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));

  mem_wait_timer #(.TMO(TMO)) u_timer (
    .clk     (CLK),
    .rst_n   (Reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.MemReady) begin
          state_d = ST_DECODE;
        end else if (tmr_expired) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end
      end
      ST_DECODE: begin
        op_d = bus.Opcode;
        if (op_supported(bus.Opcode)) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if (op_q == OPC_BEQ) begin
          state_d = ST_FETCH;
        end else if ((op_q == OPC_LW) || (op_q == OPC_SW)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.MemReady) begin
          state_d = (op_q == OPC_LW) ? ST_WB : ST_FETCH;
        end else if (tmr_expired) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end
      end
      ST_WB:     state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_TRAP;
    endcase
  end

  // Strobes are registered against the state being entered, so they line up with State.
  always_comb begin
    ctrl_d = CTRL_NONE;
    case (state_d)
      ST_FETCH:  ctrl_d.mem_read = 1'b1;
      ST_DECODE: begin
        ctrl_d.ir_write = 1'b1;
        ctrl_d.pc_write = 1'b1;
      end
      ST_EXEC: begin
        if (op_d == OPC_R) begin
          ctrl_d.reg_dst = 1'b1;
        end else if (op_d == OPC_BEQ) begin
          ctrl_d.branch   = 1'b1;
          ctrl_d.pc_write = bus.Zero;
        end else begin
          ctrl_d.alu_src = 1'b1;
        end
      end
      ST_MEM: begin
        if (op_d == OPC_LW) begin
          ctrl_d.mem_read = 1'b1;
        end else begin
          ctrl_d.mem_write = 1'b1;
        end
      end
      ST_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = (op_d == OPC_LW);
        ctrl_d.reg_dst    = (op_d == OPC_R);
      end
      default:   ctrl_d = CTRL_NONE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      ctrl_q    <= CTRL_NONE;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.ALUSrc    = ctrl_q.alu_src;
  assign bus.MemtoReg  = ctrl_q.mem_to_reg;
  assign bus.RegDst    = ctrl_q.reg_dst;
  assign bus.RegWrite  = ctrl_q.reg_write;
  assign bus.MemRead   = ctrl_q.mem_read;
  assign bus.MemWrite  = ctrl_q.mem_write;
  assign bus.Branch    = ctrl_q.branch;
  assign bus.IRWrite   = ctrl_q.ir_write;
  assign bus.PCWrite   = ctrl_q.pc_write;
  assign bus.IllegalOp = illegal_q;
  assign bus.BusError  = bus_err_q;
  assign bus.State     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: table of instruction traces plus
// hand sequences for memory stalls, timeout, illegal opcode and async reset.
module tb_multicycle_control_unit;

  localparam logic [2:0] S_IDLE = 3'd0, S_FET = 3'd1, S_DEC = 3'd2, S_EXE = 3'd3;
  localparam logic [2:0] S_MEM  = 3'd4, S_WB  = 3'd5, S_TRAP = 3'd6;

  // {ALUSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite, Branch, IRWrite, PCWrite}
  localparam logic [8:0] C_ALU = 9'h100, C_M2R = 9'h080, C_RDST = 9'h040, C_RW = 9'h020;
  localparam logic [8:0] C_MR  = 9'h010, C_MW  = 9'h008, C_BR   = 9'h004, C_IR = 9'h002;
  localparam logic [8:0] C_PC  = 9'h001, C_NONE = 9'h000;

  typedef struct packed {
    logic [5:0]      opc;
    logic            zero;
    logic [2:0]      n;
    logic [4:0][2:0] st;
    logic [4:0][8:0] ctl;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;
  vec_t vecs[6];

  mcu_if #(.OPW(6)) bus ();

  multicycle_control_unit #(.OPW(6), .TMO(15)) dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [5:0] opc, input logic z, input logic [2:0] n,
                              input logic [2:0] s0, s1, s2, s3, s4,
                              input logic [8:0] c0, c1, c2, c3, c4);
    vec_t v;
    v.opc = opc; v.zero = z; v.n = n;
    v.st[0] = s0; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4;
    v.ctl[0] = c0; v.ctl[1] = c1; v.ctl[2] = c2; v.ctl[3] = c3; v.ctl[4] = c4;
    return v;
  endfunction

  function automatic logic [8:0] ctl();
    return {bus.ALUSrc, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.MemRead,
            bus.MemWrite, bus.Branch, bus.IRWrite, bus.PCWrite};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic chk_cycle(input string tag, input logic [2:0] st, input logic [8:0] c);
    chk({tag, ".state"}, {29'd0, bus.State}, {29'd0, st});
    chk({tag, ".ctrl"}, {23'd0, ctl()}, {23'd0, c});
    chk({tag, ".excl"}, {30'd0, bus.MemRead & bus.MemWrite, bus.RegWrite & bus.MemWrite}, 32'd0);
  endtask

  task automatic chk_flags(input string tag, input logic ill, input logic berr);
    chk({tag, ".flags"}, {30'd0, bus.IllegalOp, bus.BusError}, {30'd0, ill, berr});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.Opcode   = '0;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b0;

    vecs[0] = mk(6'd0,  1'b0, 3'd4, S_DEC, S_EXE, S_WB,  S_FET, S_IDLE,
                 C_IR | C_PC, C_RDST, C_RW | C_RDST, C_MR, C_NONE);
    vecs[1] = mk(6'd8,  1'b1, 3'd4, S_DEC, S_EXE, S_WB,  S_FET, S_IDLE,
                 C_IR | C_PC, C_ALU, C_RW, C_MR, C_NONE);
    vecs[2] = mk(6'd4,  1'b1, 3'd3, S_DEC, S_EXE, S_FET, S_IDLE, S_IDLE,
                 C_IR | C_PC, C_BR | C_PC, C_MR, C_NONE, C_NONE);
    vecs[3] = mk(6'd4,  1'b0, 3'd3, S_DEC, S_EXE, S_FET, S_IDLE, S_IDLE,
                 C_IR | C_PC, C_BR, C_MR, C_NONE, C_NONE);
    vecs[4] = mk(6'd35, 1'b0, 3'd5, S_DEC, S_EXE, S_MEM, S_WB,  S_FET,
                 C_IR | C_PC, C_ALU, C_MR, C_RW | C_M2R, C_MR);
    vecs[5] = mk(6'd43, 1'b0, 3'd4, S_DEC, S_EXE, S_MEM, S_FET, S_IDLE,
                 C_IR | C_PC, C_ALU, C_MW, C_MR, C_NONE);

    #2;
    chk_cycle("reset", S_IDLE, C_NONE);
    chk_flags("reset", 1'b0, 1'b0);
    bus.MemReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cycle("reset_held", S_IDLE, C_NONE);
    #3 rst_n = 1'b1;
    step();
    chk_cycle("first_fetch", S_FET, C_MR);

    // Table: each trace starts in FETCH with MemReady high throughout.
    for (int i = 0; i < 6; i++) begin
      bus.Opcode = vecs[i].opc;
      bus.Zero   = vecs[i].zero;
      for (int c = 0; c < int'(vecs[i].n); c++) begin
        step();
        chk_cycle($sformatf("vec%0d.c%0d", i, c), vecs[i].st[c], vecs[i].ctl[c]);
      end
    end

    // LW with MemReady withheld for the first three MEM cycles.
    bus.Opcode = 6'd35;
    step(); chk_cycle("lw_wait.dec", S_DEC, C_IR | C_PC);
    step(); chk_cycle("lw_wait.exe", S_EXE, C_ALU);
    bus.MemReady = 1'b0;
    for (int m = 1; m <= 3; m++) begin
      step(); chk_cycle($sformatf("lw_wait.m%0d", m), S_MEM, C_MR);
    end
    step(); chk_cycle("lw_wait.m4", S_MEM, C_MR);
    bus.MemReady = 1'b1;
    step(); chk_cycle("lw_wait.wb", S_WB, C_RW | C_M2R);
    step(); chk_cycle("lw_wait.fetch", S_FET, C_MR);

    // Asynchronous reset in the middle of an SW memory wait.
    bus.Opcode = 6'd43;
    step(); chk_cycle("abort.dec", S_DEC, C_IR | C_PC);
    step(); chk_cycle("abort.exe", S_EXE, C_ALU);
    bus.MemReady = 1'b0;
    step(); chk_cycle("abort.mem", S_MEM, C_MW);
    #3 rst_n = 1'b0;
    #1 chk_cycle("abort.now", S_IDLE, C_NONE);
    step(); chk_cycle("abort.held", S_IDLE, C_NONE);
    #2 rst_n = 1'b1;
    step(); chk_cycle("abort.refetch", S_FET, C_MR);

    // FETCH: ready arrives on the 15th wait cycle, exactly at the limit.
    for (int f = 2; f <= 14; f++) begin
      step(); chk_cycle($sformatf("edge.f%0d", f), S_FET, C_MR);
    end
    step(); chk_cycle("edge.f15", S_FET, C_MR);
    bus.MemReady = 1'b1;
    step(); chk_cycle("edge.dec", S_DEC, C_IR | C_PC);
    chk_flags("edge", 1'b0, 1'b0);

    // SW with MemReady never arriving: timeout after 15 wait cycles.
    step(); chk_cycle("tmo.exe", S_EXE, C_ALU);
    bus.MemReady = 1'b0;
    for (int w = 1; w <= 15; w++) begin
      step(); chk_cycle($sformatf("tmo.w%0d", w), S_MEM, C_MW);
    end
    step(); chk_cycle("tmo.trap", S_TRAP, C_NONE);
    chk_flags("tmo", 1'b0, 1'b1);
    bus.MemReady = 1'b1;
    repeat (3) begin
      step(); chk_cycle("tmo.absorb", S_TRAP, C_NONE);
    end

    // Illegal opcode after a fresh reset.
    rst_n = 1'b0;
    #1 chk_flags("ill.reset", 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    bus.Opcode = 6'd63;
    step(); chk_cycle("ill.fetch", S_FET, C_MR);
    step(); chk_cycle("ill.dec", S_DEC, C_IR | C_PC);
    step(); chk_cycle("ill.trap", S_TRAP, C_NONE);
    chk_flags("ill", 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      bus.MemReady = k[0];
      bus.Opcode   = (k[1]) ? 6'd0 : 6'd35;
      step(); chk_cycle($sformatf("ill.hold%0d", k), S_TRAP, C_NONE);
    end
    chk_flags("ill.end", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
